// File: rtl/int_issue_queue_pkg.sv
// Shared types for the integer reservation queue: dispatch packet layout,
// CDB broadcast bundle, opcode constants and the operand wakeup rule.
package int_issue_queue_pkg;

  localparam int TAG_W = 6;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs1_data_valid;
    logic             rs2_data_valid;
    logic [TAG_W-1:0] rd_tag;
  } queue_data;

  typedef struct packed {
    queue_data   common_data;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
  } int_queue_data;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } cdb_bus_t;

  // Each operand is captured independently, so one broadcast can wake both.
  function automatic queue_data wake(input queue_data d, input cdb_bus_t c);
    queue_data r;
    r = d;
    if (c.valid && !d.rs1_data_valid && (c.tag == d.rs1_tag)) begin
      r.rs1_data       = c.data;
      r.rs1_data_valid = 1'b1;
    end
    if (c.valid && !d.rs2_data_valid && (c.tag == d.rs2_tag)) begin
      r.rs2_data       = c.data;
      r.rs2_data_valid = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/int_issue_queue_entry.sv
// One queue slot: holds a packet, snoops the CDB, and can load from dispatch
// or shift in the contents of the next-younger slot.
module iq_entry
  import int_issue_queue_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  cdb_bus_t      cdb,
  input  logic          load,
  input  int_queue_data load_data,
  input  logic          shift,
  input  logic          shift_valid,
  input  int_queue_data shift_data,
  output logic          valid,
  output int_queue_data data
);

  logic          nxt_valid;
  int_queue_data nxt_data;

  // Load wins over shift: on a same-cycle issue the new packet lands in the
  // slot vacated by the compaction. Wakeup applies to whatever is written.
  always_comb begin
    nxt_valid = valid;
    nxt_data  = data;
    if (load) begin
      nxt_valid = 1'b1;
      nxt_data  = load_data;
    end else if (shift) begin
      nxt_valid = shift_valid;
      nxt_data  = shift_data;
    end
    nxt_data.common_data = wake(nxt_data.common_data, cdb);
    if (flush) nxt_valid = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= nxt_valid;
      data  <= nxt_data;
    end
  end

endmodule

// File: rtl/int_issue_queue.sv
// Age-ordered compacting integer issue queue: oldest-ready select, CDB wakeup
// with dispatch-cycle bypass, valid/ready issue handshake and flush.
module int_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en_int_dispatch,
  input  int_issue_queue_pkg::int_queue_data     dispatcher_2_int_queue,
  input  logic                                   cdb_valid,
  input  logic [TAG_W-1:0]                       cdb_tag,
  input  logic [31:0]                            cdb_data,
  input  logic                                   flush,
  input  logic                                   exe_ready,
  output logic                                   issue_valid,
  output int_issue_queue_pkg::int_queue_data     issue_pkt,
  output logic                                   queue_full,
  output logic                                   queue_empty,
  output logic [$clog2(DEPTH+1)-1:0]             occupancy
);
  import int_issue_queue_pkg::*;

  localparam int OCC_W = $clog2(DEPTH+1);

  // Handshake: an issue is consumed on any rising edge where issue_valid and
  // exe_ready are both high; issue_pkt holds steady otherwise unless an older
  // entry becomes ready or a flush clears the queue.

  cdb_bus_t      cdb;
  logic [DEPTH-1:0] slot_valid, slot_ready, shift, load;
  int_queue_data slot_data [DEPTH];
  logic [OCC_W-1:0] occ_q, alloc_idx;
  logic          alloc, fire;

  assign cdb         = {cdb_valid, cdb_tag, cdb_data};
  assign queue_full  = (occ_q == OCC_W'(DEPTH));
  assign queue_empty = (occ_q == '0);
  assign occupancy   = occ_q;
  assign alloc       = en_int_dispatch && !queue_full;
  assign fire        = issue_valid && exe_ready;
  assign alloc_idx   = fire ? (occ_q - OCC_W'(1)) : occ_q;

  // Oldest-ready select; every slot at or above the selected one shifts down.
  always_comb begin
    issue_valid = 1'b0;
    issue_pkt   = '0;
    shift       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_ready[i] && !issue_valid) begin
        issue_valid = 1'b1;
        issue_pkt   = slot_data[i];
      end
      shift[i] = issue_valid && exe_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     occ_q <= '0;
    else if (flush) occ_q <= '0;
    else            occ_q <= occ_q + OCC_W'(alloc) - OCC_W'(fire);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic          nxt_valid;
    int_queue_data nxt_data;

    if (i == DEPTH-1) begin : g_tail
      assign nxt_valid = 1'b0;
      assign nxt_data  = '0;
    end else begin : g_mid
      assign nxt_valid = slot_valid[i+1];
      assign nxt_data  = slot_data[i+1];
    end

    assign slot_ready[i] = slot_valid[i]
                         & slot_data[i].common_data.rs1_data_valid
                         & slot_data[i].common_data.rs2_data_valid;
    assign load[i] = alloc && (alloc_idx == OCC_W'(i));

    iq_entry u_entry (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .cdb         (cdb),
      .load        (load[i]),
      .load_data   (dispatcher_2_int_queue),
      .shift       (shift[i]),
      .shift_valid (nxt_valid),
      .shift_data  (nxt_data),
      .valid       (slot_valid[i]),
      .data        (slot_data[i])
    );
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// Self-checking bench for int_issue_queue: directed scenarios with a
// scoreboard of expected issues checked on every accepted handshake.
module tb_int_issue_queue;
  import int_issue_queue_pkg::*;

  localparam int KW = 6 + 32 + 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_int_dispatch;
  int_queue_data dispatcher_2_int_queue;
  logic          cdb_valid;
  logic [5:0]    cdb_tag;
  logic [31:0]   cdb_data;
  logic          flush;
  logic          exe_ready;
  logic          issue_valid;
  int_queue_data issue_pkt;
  logic          queue_full;
  logic          queue_empty;
  logic [2:0]    occupancy;

  logic [KW-1:0] exp_q[$];
  logic [KW-1:0] mon_exp, mon_got;
  int tests_run = 0;
  int fails = 0;

  int_issue_queue #(.DEPTH(4), .TAG_W(6)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .en_int_dispatch        (en_int_dispatch),
    .dispatcher_2_int_queue (dispatcher_2_int_queue),
    .cdb_valid              (cdb_valid),
    .cdb_tag                (cdb_tag),
    .cdb_data               (cdb_data),
    .flush                  (flush),
    .exe_ready              (exe_ready),
    .issue_valid            (issue_valid),
    .issue_pkt              (issue_pkt),
    .queue_full             (queue_full),
    .queue_empty            (queue_empty),
    .occupancy              (occupancy)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [KW-1:0] key_of(input logic [5:0] rd, input logic [31:0] a,
                                           input logic [31:0] b);
    return {rd, a, b};
  endfunction

  function automatic int_queue_data mk(input logic [6:0] op, input logic [5:0] rd,
                                       input logic [5:0] t1, input logic v1, input logic [31:0] d1,
                                       input logic [5:0] t2, input logic v2, input logic [31:0] d2);
    int_queue_data p;
    p = '0;
    p.opcode = op;
    p.common_data.rd_tag = rd;
    p.common_data.rs1_tag = t1;
    p.common_data.rs1_data_valid = v1;
    p.common_data.rs1_data = d1;
    p.common_data.rs2_tag = t2;
    p.common_data.rs2_data_valid = v2;
    p.common_data.rs2_data = d2;
    return p;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dispatch(input int_queue_data p);
    en_int_dispatch = 1'b1;
    dispatcher_2_int_queue = p;
  endtask

  task automatic drive_cdb(input logic v, input logic [5:0] t, input logic [31:0] d);
    cdb_valid = v;
    cdb_tag = t;
    cdb_data = d;
  endtask

  // scoreboard: every accepted handshake pops one expected issue
  always @(negedge clk) begin
    if (rst_n && issue_valid && exe_ready) begin
      tests_run++;
      mon_got = {issue_pkt.common_data.rd_tag, issue_pkt.common_data.rs1_data,
                 issue_pkt.common_data.rs2_data};
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL issue_unexpected: got rd_tag=%0d rs1=%h rs2=%h, expected no issue",
                 issue_pkt.common_data.rd_tag, issue_pkt.common_data.rs1_data,
                 issue_pkt.common_data.rs2_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp || issue_pkt.common_data.rs1_data_valid !== 1'b1 ||
            issue_pkt.common_data.rs2_data_valid !== 1'b1) begin
          fails++;
          $display("FAIL issue_pkt: got {rd,rs1,rs2}=%h v=%b%b, expected %h v=11", mon_got,
                   issue_pkt.common_data.rs1_data_valid, issue_pkt.common_data.rs2_data_valid,
                   mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    en_int_dispatch = 1'b0;
    dispatcher_2_int_queue = '0;
    drive_cdb(1'b0, '0, '0);
    flush = 1'b0;
    exe_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (occupancy !== 3'd0 || issue_valid !== 1'b0 || queue_full !== 1'b0 ||
        queue_empty !== 1'b1) begin
      fails++;
      $display("FAIL reset_flags: got occ=%0d iv=%b full=%b empty=%b, expected 0 0 0 1",
               occupancy, issue_valid, queue_full, queue_empty);
    end
    tests_run++;
    if (issue_pkt !== '0) begin
      fails++;
      $display("FAIL reset_pkt: got %h, expected 0", issue_pkt);
    end
  endtask

  task automatic test_addi();
    exe_ready = 1'b1;
    drive_dispatch(mk(OP_IMM, 6'd5, 6'd0, 1'b1, 32'd10, 6'd0, 1'b1, 32'd7));
    exp_q.push_back(key_of(6'd5, 32'd10, 32'd7));
    tick();
    en_int_dispatch = 1'b0;
    tests_run++;
    if (occupancy !== 3'd1 || issue_valid !== 1'b1 || issue_pkt.common_data.rd_tag !== 6'd5) begin
      fails++;
      $display("FAIL addi_ready: got occ=%0d iv=%b rd=%0d, expected 1 1 5",
               occupancy, issue_valid, issue_pkt.common_data.rd_tag);
    end
    tick();
    tests_run++;
    if (occupancy !== 3'd0 || queue_empty !== 1'b1) begin
      fails++;
      $display("FAIL addi_drain: got occ=%0d empty=%b, expected 0 1", occupancy, queue_empty);
    end
    exe_ready = 1'b0;
  endtask

  task automatic test_cdb_wakeup();
    logic [31:0] b;
    b = 32'($urandom_range(0, 65535));
    exe_ready = 1'b1;
    drive_dispatch(mk(OP_REG, 6'd6, 6'd9, 1'b0, 32'd0, 6'd3, 1'b1, b));
    tick();
    en_int_dispatch = 1'b0;
    drive_cdb(1'b1, 6'd9, 32'h1234);
    tests_run++;
    if (occupancy !== 3'd1 || issue_valid !== 1'b0) begin
      fails++;
      $display("FAIL cdb_wait: got occ=%0d iv=%b, expected 1 0", occupancy, issue_valid);
    end
    exp_q.push_back(key_of(6'd6, 32'h1234, b));
    tick();
    drive_cdb(1'b0, '0, '0);
    tests_run++;
    if (issue_valid !== 1'b1 || issue_pkt.common_data.rs1_data !== 32'h1234) begin
      fails++;
      $display("FAIL cdb_wake: got iv=%b rs1=%h, expected 1 00001234",
               issue_valid, issue_pkt.common_data.rs1_data);
    end
    tick();
    tests_run++;
    if (occupancy !== 3'd0) begin
      fails++;
      $display("FAIL cdb_drain: got occ=%0d, expected 0", occupancy);
    end
    exe_ready = 1'b0;
  endtask

  task automatic test_bypass();
    exe_ready = 1'b1;
    drive_dispatch(mk(OP_REG, 6'd7, 6'd12, 1'b0, 32'd0, 6'd0, 1'b1, 32'd3));
    drive_cdb(1'b1, 6'd12, 32'hAA);
    exp_q.push_back(key_of(6'd7, 32'hAA, 32'd3));
    tick();
    en_int_dispatch = 1'b0;
    drive_cdb(1'b0, '0, '0);
    tests_run++;
    if (issue_valid !== 1'b1 || issue_pkt.common_data.rs1_data !== 32'hAA) begin
      fails++;
      $display("FAIL bypass: got iv=%b rs1=%h, expected 1 000000aa",
               issue_valid, issue_pkt.common_data.rs1_data);
    end
    tick();
    exe_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [31:0] b [4];
    exe_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b[i] = 32'($urandom_range(1, 1000));
      drive_dispatch(mk(OP_REG, 6'(10 + i), 6'(20 + i), 1'b0, 32'd0, 6'd0, 1'b1, b[i]));
      tick();
    end
    drive_dispatch(mk(OP_IMM, 6'd14, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1));
    tests_run++;
    if (queue_full !== 1'b1 || occupancy !== 3'd4) begin
      fails++;
      $display("FAIL full_flag: got full=%b occ=%0d, expected 1 4", queue_full, occupancy);
    end
    tick();
    en_int_dispatch = 1'b0;
    tests_run++;
    if (occupancy !== 3'd4 || issue_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_drop: got occ=%0d iv=%b, expected 4 0", occupancy, issue_valid);
    end
    drive_cdb(1'b1, 6'd22, 32'h22);
    exp_q.push_back(key_of(6'd12, 32'h22, b[2]));
    tick();
    drive_cdb(1'b0, '0, '0);
    tests_run++;
    if (issue_valid !== 1'b1 || issue_pkt.common_data.rd_tag !== 6'd12) begin
      fails++;
      $display("FAIL full_slot2: got iv=%b rd=%0d, expected 1 12",
               issue_valid, issue_pkt.common_data.rd_tag);
    end
    exe_ready = 1'b1;
    tick();
    tests_run++;
    if (occupancy !== 3'd3 || issue_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_after: got occ=%0d iv=%b, expected 3 0", occupancy, issue_valid);
    end
    drive_cdb(1'b1, 6'd20, 32'h20);
    exp_q.push_back(key_of(6'd10, 32'h20, b[0]));
    tick();
    drive_cdb(1'b1, 6'd21, 32'h21);
    exp_q.push_back(key_of(6'd11, 32'h21, b[1]));
    tick();
    drive_cdb(1'b1, 6'd23, 32'h23);
    exp_q.push_back(key_of(6'd13, 32'h23, b[3]));
    tests_run++;
    if (occupancy !== 3'd2) begin
      fails++;
      $display("FAIL full_shift: got occ=%0d, expected 2", occupancy);
    end
    tick();
    drive_cdb(1'b0, '0, '0);
    tick();
    exe_ready = 1'b0;
    tests_run++;
    if (occupancy !== 3'd0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL full_drain: got occ=%0d pending=%0d, expected 0 0", occupancy, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    exe_ready = 1'b0;
    drive_dispatch(mk(OP_IMM, 6'd20, 6'd0, 1'b1, 32'h5, 6'd0, 1'b1, 32'h6));
    tick();
    drive_dispatch(mk(OP_REG, 6'd21, 6'd30, 1'b0, 32'd0, 6'd0, 1'b1, 32'h7));
    tick();
    drive_dispatch(mk(OP_REG, 6'd22, 6'd31, 1'b0, 32'd0, 6'd0, 1'b1, 32'h8));
    tests_run++;
    if (occupancy !== 3'd2 || issue_valid !== 1'b1 || issue_pkt.common_data.rd_tag !== 6'd20) begin
      fails++;
      $display("FAIL b2b_pre: got occ=%0d iv=%b rd=%0d, expected 2 1 20",
               occupancy, issue_valid, issue_pkt.common_data.rd_tag);
    end
    exe_ready = 1'b1;
    exp_q.push_back(key_of(6'd20, 32'h5, 32'h6));
    tick();
    en_int_dispatch = 1'b0;
    exe_ready = 1'b0;
    tests_run++;
    if (occupancy !== 3'd2 || issue_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_occ: got occ=%0d iv=%b, expected 2 0", occupancy, issue_valid);
    end
    drive_cdb(1'b1, 6'd31, 32'h31);
    tick();
    tests_run++;
    if (issue_valid !== 1'b1 || issue_pkt.common_data.rd_tag !== 6'd22) begin
      fails++;
      $display("FAIL b2b_slot1: got iv=%b rd=%0d, expected 1 22",
               issue_valid, issue_pkt.common_data.rd_tag);
    end
    drive_cdb(1'b1, 6'd30, 32'h30);
    tick();
    drive_cdb(1'b0, '0, '0);
    tests_run++;
    if (issue_pkt.common_data.rd_tag !== 6'd21) begin
      fails++;
      $display("FAIL b2b_older: got rd=%0d, expected 21", issue_pkt.common_data.rd_tag);
    end
    exp_q.push_back(key_of(6'd21, 32'h30, 32'h7));
    exp_q.push_back(key_of(6'd22, 32'h31, 32'h8));
    exe_ready = 1'b1;
    repeat (2) tick();
    exe_ready = 1'b0;
    tests_run++;
    if (occupancy !== 3'd0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_drain: got occ=%0d pending=%0d, expected 0 0", occupancy, exp_q.size());
    end
  endtask

  task automatic test_flush();
    exe_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_dispatch(mk(OP_REG, 6'(40 + i), 6'(40 + i), 1'b0, 32'd0, 6'd0, 1'b1, 32'd1));
      tick();
    end
    drive_dispatch(mk(OP_IMM, 6'd50, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 32'd3));
    drive_cdb(1'b1, 6'd40, 32'h40);
    flush = 1'b1;
    tests_run++;
    if (occupancy !== 3'd3) begin
      fails++;
      $display("FAIL flush_pre: got occ=%0d, expected 3", occupancy);
    end
    tick();
    flush = 1'b0;
    en_int_dispatch = 1'b0;
    drive_cdb(1'b0, '0, '0);
    tests_run++;
    if (occupancy !== 3'd0 || issue_valid !== 1'b0 || queue_empty !== 1'b1) begin
      fails++;
      $display("FAIL flush_clear: got occ=%0d iv=%b empty=%b, expected 0 0 1",
               occupancy, issue_valid, queue_empty);
    end
    tick();
    tests_run++;
    if (occupancy !== 3'd0 || issue_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_hold: got occ=%0d iv=%b, expected 0 0", occupancy, issue_valid);
    end
  endtask

  task automatic test_async_reset();
    exe_ready = 1'b0;
    drive_dispatch(mk(OP_LUI, 6'd34, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd0));
    tick();
    drive_dispatch(mk(OP_AUIPC, 6'd35, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 32'd0));
    tick();
    en_int_dispatch = 1'b0;
    tests_run++;
    if (occupancy !== 3'd2 || issue_valid !== 1'b1) begin
      fails++;
      $display("FAIL arst_pre: got occ=%0d iv=%b, expected 2 1", occupancy, issue_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (occupancy !== 3'd0 || issue_valid !== 1'b0 || queue_full !== 1'b0 ||
        queue_empty !== 1'b1 || issue_pkt !== '0) begin
      fails++;
      $display("FAIL arst_now: got occ=%0d iv=%b full=%b empty=%b pkt_nz=%b, expected 0 0 0 1 0",
               occupancy, issue_valid, queue_full, queue_empty, |issue_pkt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (occupancy !== 3'd0 || issue_valid !== 1'b0) begin
      fails++;
      $display("FAIL arst_post: got occ=%0d iv=%b, expected 0 0", occupancy, issue_valid);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_cdb_wakeup();
    test_bypass();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d pending issues, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
